// File: rtl/pent1m_pkg.sv
// Shared definitions for the Pentagon-1024 I/O write front end.
//   - port decode constants (xxF7 low byte, full EFF7 address)
//   - I/O-cycle FSM state encoding (2 bit)
//   - EFF7 data bit positions
//   - decode helper returning which port an address selects
package pent1m_pkg;

  localparam logic [7:0]  PORT_F7_LO = 8'hF7;
  localparam logic [15:0] PORT_EFF7  = 16'hEFF7;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY     = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;

  localparam int EFF7_RAM0_BIT  = 3;
  localparam int EFF7_1MOFF_BIT = 2;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_7FFD = 2'd1,
    SEL_F7   = 2'd2,
    SEL_EFF7 = 2'd3
  } port_sel_e;

  // Priority: full EFF7 match, then xxF7 (if enabled), then 7FFD partial decode.
  function automatic port_sel_e decode_port(input logic [15:0] a, input logic f7_en);
    if (a == PORT_EFF7) begin
      return SEL_EFF7;
    end
    if ((a[7:0] == PORT_F7_LO) && f7_en) begin
      return SEL_F7;
    end
    if (!a[15] && !a[1]) begin
      return SEL_7FFD;
    end
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/io_wr_detect.sv
// Z80 I/O write cycle detector.
// Tracks I/O cycles on the zpos strobe and emits one fclk-wide io_wr_stb
// on the first zpos of a write cycle (IORQ+WR low, M1 high).
//   fclk, rst_n      clock / async active-low reset
//   zpos             Z80 clock rising-edge strobe (fclk wide)
//   iorq_n, wr_n     Z80 bus controls, active-low
//   m1_n             Z80 M1; low with IORQ marks interrupt acknowledge
//   io_wr_stb        single-fclk write strobe (combinational)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no I/O cycle; watching for IORQ low on a zpos
// BUSY     | I/O cycle seen (strobe already given or suppressed); wait IORQ high
// WAIT_END | reset state; a cycle already running at reset gives no strobe
module io_wr_detect
  import pent1m_pkg::*;
(
  input  logic fclk,
  input  logic rst_n,
  input  logic zpos,
  input  logic iorq_n,
  input  logic wr_n,
  input  logic m1_n,
  output logic io_wr_stb
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d   = state_q;
    io_wr_stb = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Any IORQ cycle (write, read or intack) moves to BUSY, so a late
        // WR within the same cycle cannot fire a second strobe.
        if (zpos && !iorq_n) begin
          state_d   = ST_BUSY;
          io_wr_stb = !wr_n && m1_n;
        end
      end
      ST_BUSY, ST_WAIT_END: begin
        if (zpos && iorq_n) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_END;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_END;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pent1m_port_writer.sv
// Z80 I/O-write front end for the memory pagers.
// Decodes writes to xxF7 (ATM pager), 7FFD and EFF7, issues one fclk-wide
// strobe per accepted write and holds the Pentagon-1024 paging state.
//   fclk, rst_n          clock / async active-low reset
//   zpos, zneg           Z80 clock edge strobes (only zpos is needed)
//   za, zd               Z80 address / data bus
//   iorq_n, wr_n, m1_n   Z80 bus controls
//   dos                  DOS/shadow state, gates xxF7 decode
//   atmF7_wr             xxF7 write strobe (pager latches za/zd itself)
//   p7ffd_wr             accepted 7FFD write strobe
//   peff7_wr             EFF7 write strobe
//   pent1m_page          RAM page for the C000 window
//   pent1m_ROM           ROM select (7FFD d4)
//   pent1m_screen        screen select (7FFD d3)
//   pent1m_lock          7FFD lock, honoured in 128k mode only
//   pent1m_ram0_0        RAM0 mapped at 0000 (EFF7 d3)
//   pent1m_1m_on         1M addressing enabled (EFF7 d2 inverted)
module pent1m_port_writer
  import pent1m_pkg::*;
#(
  parameter bit F7_NEEDS_DOS = 1'b1
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        dos,
  output logic        atmF7_wr,
  output logic        p7ffd_wr,
  output logic        peff7_wr,
  output logic [5:0]  pent1m_page,
  output logic        pent1m_ROM,
  output logic        pent1m_screen,
  output logic        pent1m_lock,
  output logic        pent1m_ram0_0,
  output logic        pent1m_1m_on
);

  // Cycles are tracked on zpos alone; zneg is part of the bus bundle only.
  logic unused_zneg;
  assign unused_zneg = zneg;

  logic      io_wr_stb;
  port_sel_e port_sel;

  logic [5:0] page_q,   page_d;
  logic       rom_q,    rom_d;
  logic       screen_q, screen_d;
  logic       lock_q,   lock_d;
  logic       ram0_q,   ram0_d;
  logic       on1m_q,   on1m_d;

  io_wr_detect u_io_wr_detect (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .zpos      (zpos),
    .iorq_n    (iorq_n),
    .wr_n      (wr_n),
    .m1_n      (m1_n),
    .io_wr_stb (io_wr_stb)
  );

  assign port_sel = decode_port(za, dos | ~F7_NEEDS_DOS);

  assign atmF7_wr = io_wr_stb && (port_sel == SEL_F7);
  assign peff7_wr = io_wr_stb && (port_sel == SEL_EFF7);
  // Lock only bites in 128k mode; it stays latched while 1M mode ignores it.
  assign p7ffd_wr = io_wr_stb && (port_sel == SEL_7FFD) && (on1m_q || !lock_q);

  always_comb begin
    page_d   = page_q;
    rom_d    = rom_q;
    screen_d = screen_q;
    lock_d   = lock_q;
    ram0_d   = ram0_q;
    on1m_d   = on1m_q;

    if (p7ffd_wr) begin
      rom_d    = zd[4];
      screen_d = zd[3];
      if (on1m_q) begin
        page_d = {zd[5], zd[7:6], zd[2:0]};
      end else begin
        page_d = {3'b000, zd[2:0]};
        lock_d = zd[5];
      end
    end

    if (peff7_wr) begin
      ram0_d = zd[EFF7_RAM0_BIT];
      on1m_d = ~zd[EFF7_1MOFF_BIT];
      // Leaving 1M mode drops the extended page bits immediately.
      if (zd[EFF7_1MOFF_BIT]) begin
        page_d = {3'b000, page_q[2:0]};
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      page_q   <= 6'd0;
      rom_q    <= 1'b0;
      screen_q <= 1'b0;
      lock_q   <= 1'b0;
      ram0_q   <= 1'b0;
      on1m_q   <= 1'b1;
    end else begin
      page_q   <= page_d;
      rom_q    <= rom_d;
      screen_q <= screen_d;
      lock_q   <= lock_d;
      ram0_q   <= ram0_d;
      on1m_q   <= on1m_d;
    end
  end

  assign pent1m_page   = page_q;
  assign pent1m_ROM    = rom_q;
  assign pent1m_screen = screen_q;
  assign pent1m_lock   = lock_q;
  assign pent1m_ram0_0 = ram0_q;
  assign pent1m_1m_on  = on1m_q;

endmodule

// File: tb/tb_pent1m_port_writer.sv
module tb_pent1m_port_writer;

  localparam logic [1:0] K_7FFD = 2'd0;
  localparam logic [1:0] K_F7   = 2'd1;
  localparam logic [1:0] K_EFF7 = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] za;
    logic [7:0]  zd;
  } exp_t;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        zpos = 1'b0;
  logic        zneg = 1'b0;
  logic [15:0] za;
  logic [7:0]  zd;
  logic        iorq_n, wr_n, m1_n, dos;
  logic        atmF7_wr, p7ffd_wr, peff7_wr;
  logic [5:0]  pent1m_page;
  logic        pent1m_ROM, pent1m_screen, pent1m_lock, pent1m_ram0_0, pent1m_1m_on;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   phase    = 0;

  pent1m_port_writer #(.F7_NEEDS_DOS(1'b1)) dut (
    .fclk          (fclk),
    .rst_n         (rst_n),
    .zpos          (zpos),
    .zneg          (zneg),
    .za            (za),
    .zd            (zd),
    .iorq_n        (iorq_n),
    .wr_n          (wr_n),
    .m1_n          (m1_n),
    .dos           (dos),
    .atmF7_wr      (atmF7_wr),
    .p7ffd_wr      (p7ffd_wr),
    .peff7_wr      (peff7_wr),
    .pent1m_page   (pent1m_page),
    .pent1m_ROM    (pent1m_ROM),
    .pent1m_screen (pent1m_screen),
    .pent1m_lock   (pent1m_lock),
    .pent1m_ram0_0 (pent1m_ram0_0),
    .pent1m_1m_on  (pent1m_1m_on)
  );

  always #5 fclk = ~fclk;

  // Z80 clock = fclk/8; strobes change 2ns after posedge so each covers one edge.
  always @(posedge fclk) begin
    #2;
    zpos  = (phase == 0);
    zneg  = (phase == 4);
    phase = (phase + 1) % 8;
  end

  // {page, ROM, screen, lock, ram0_0, 1m_on}
  function automatic logic [10:0] regs_now();
    return {pent1m_page, pent1m_ROM, pent1m_screen, pent1m_lock, pent1m_ram0_0, pent1m_1m_on};
  endfunction

  // Scoreboard: every strobe pops one expectation; strobe kind, za, zd must match.
  always @(negedge fclk) begin
    logic [2:0] s;
    exp_t e;
    s = {peff7_wr, atmF7_wr, p7ffd_wr};
    for (int k = 0; k < 3; k++) begin
      if (s[k]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: kind %0d za=%h zd=%h, required no strobe", k, za, zd);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== 2'(k) || e.za !== za || e.zd !== zd) begin
            n_fail++;
            $display("FAIL strobe_match: got kind %0d za=%h zd=%h, required kind %0d za=%h zd=%h",
                     k, za, zd, e.kind, e.za, e.zd);
          end
        end
      end
    end
  end

  task automatic wait_z();
    int n = 0;
    do begin
      @(posedge fclk);
      n++;
    end while (!zpos && n < 32);
    if (!zpos) begin
      n_checks++;
      n_fail++;
      $display("FAIL zpos_timeout: no zpos in %0d fclk, required within 32", n);
    end
  endtask

  // One Z80 I/O cycle: address phase, IORQ(+WR) held for 'hold' Z80 clocks.
  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input bit wr_first,
                          input bit late_wr, input bit m1, input int hold);
    wait_z();
    #1 za = a; zd = d; m1_n = ~m1;
    wait_z();
    #1 iorq_n = 1'b0; wr_n = ~wr_first;
    for (int i = 0; i < hold; i++) begin
      wait_z();
      if (i == 0 && late_wr) #1 wr_n = 1'b0;
    end
    #1 iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    wait_z();
    wait_z();
  endtask

  task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = k; e.za = a; e.zd = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    n_checks++;
    if (regs_now() !== 11'b000000_00001) begin
      n_fail++;
      $display("FAIL reset_regs: got %b, required %b", regs_now(), 11'b000000_00001);
    end
    n_checks++;
    if ({atmF7_wr, p7ffd_wr, peff7_wr} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, required 000", {atmF7_wr, p7ffd_wr, peff7_wr});
    end
  endtask

  task automatic test_7ffd_basic();
    push(K_7FFD, 16'h7FFD, 8'h17);
    io_cycle(16'h7FFD, 8'h17, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000111_10001) begin
      n_fail++;
      $display("FAIL p7ffd_0x17: got %b, required %b", regs_now(), 11'b000111_10001);
    end
  endtask

  task automatic test_lock_128k();
    push(K_EFF7, 16'hEFF7, 8'h04);
    io_cycle(16'hEFF7, 8'h04, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000111_10000) begin
      n_fail++;
      $display("FAIL eff7_0x04: got %b, required %b", regs_now(), 11'b000111_10000);
    end
    push(K_7FFD, 16'h7FFD, 8'h23);
    io_cycle(16'h7FFD, 8'h23, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000011_00100) begin
      n_fail++;
      $display("FAIL p7ffd_lock_set: got %b, required %b", regs_now(), 11'b000011_00100);
    end
    io_cycle(16'h7FFD, 8'h05, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000011_00100) begin
      n_fail++;
      $display("FAIL p7ffd_locked: got %b, required %b", regs_now(), 11'b000011_00100);
    end
  endtask

  task automatic test_1m_mode();
    push(K_EFF7, 16'hEFF7, 8'h00);
    io_cycle(16'hEFF7, 8'h00, 1, 0, 0, 1);
    push(K_7FFD, 16'h7FFD, 8'hE1);
    io_cycle(16'h7FFD, 8'hE1, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b111001_00101) begin
      n_fail++;
      $display("FAIL p7ffd_1m_0xE1: got %b, required %b", regs_now(), 11'b111001_00101);
    end
    push(K_EFF7, 16'hEFF7, 8'h08);
    io_cycle(16'hEFF7, 8'h08, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b111001_00111) begin
      n_fail++;
      $display("FAIL eff7_0x08: got %b, required %b", regs_now(), 11'b111001_00111);
    end
    push(K_EFF7, 16'hEFF7, 8'h0C);
    io_cycle(16'hEFF7, 8'h0C, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000001_00110) begin
      n_fail++;
      $display("FAIL eff7_truncate: got %b, required %b", regs_now(), 11'b000001_00110);
    end
    io_cycle(16'h7FFD, 8'h10, 1, 0, 0, 1);
    push(K_EFF7, 16'hEFF7, 8'h08);
    io_cycle(16'hEFF7, 8'h08, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000001_00111) begin
      n_fail++;
      $display("FAIL relock_128k: got %b, required %b", regs_now(), 11'b000001_00111);
    end
  endtask

  task automatic test_f7_dos();
    dos = 1'b0;
    io_cycle(16'h3FF7, 8'h55, 1, 0, 0, 1);
    dos = 1'b1;
    push(K_F7, 16'h3FF7, 8'h55);
    io_cycle(16'h3FF7, 8'h55, 1, 0, 0, 1);
    push(K_EFF7, 16'hEFF7, 8'h08);
    io_cycle(16'hEFF7, 8'h08, 1, 0, 0, 1);
    dos = 1'b0;
    n_checks++;
    if (regs_now() !== 11'b000001_00111) begin
      n_fail++;
      $display("FAIL f7_no_state: got %b, required %b", regs_now(), 11'b000001_00111);
    end
  endtask

  task automatic test_cycle_types();
    push(K_7FFD, 16'h7FFD, 8'h1A);
    io_cycle(16'h7FFD, 8'h1A, 1, 0, 0, 4);
    n_checks++;
    if (regs_now() !== 11'b000010_11111) begin
      n_fail++;
      $display("FAIL wait_states: got %b, required %b", regs_now(), 11'b000010_11111);
    end
    io_cycle(16'h7FFD, 8'h07, 1, 0, 1, 2);
    io_cycle(16'h7FFD, 8'h07, 0, 1, 0, 3);
    n_checks++;
    if (regs_now() !== 11'b000010_11111) begin
      n_fail++;
      $display("FAIL intack_in: got %b, required %b", regs_now(), 11'b000010_11111);
    end
  endtask

  task automatic test_back_to_back();
    push(K_7FFD, 16'h7FFD, 8'h00);
    push(K_7FFD, 16'h7FFD, 8'h07);
    io_cycle(16'h7FFD, 8'h00, 1, 0, 0, 1);
    io_cycle(16'h7FFD, 8'h07, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000111_00111) begin
      n_fail++;
      $display("FAIL back_to_back: got %b, required %b", regs_now(), 11'b000111_00111);
    end
  endtask

  task automatic test_reset_mid_cycle();
    wait_z();
    #1 za = 16'h7FFD; zd = 8'h07; m1_n = 1'b1;
    wait_z();
    #1 iorq_n = 1'b0; wr_n = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (regs_now() !== 11'b000000_00001) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required %b", regs_now(), 11'b000000_00001);
    end
    #20 rst_n = 1'b1;
    wait_z();
    wait_z();
    #1 iorq_n = 1'b1; wr_n = 1'b1;
    wait_z();
    wait_z();
    n_checks++;
    if (regs_now() !== 11'b000000_00001) begin
      n_fail++;
      $display("FAIL reset_release_cycle: got %b, required %b", regs_now(), 11'b000000_00001);
    end
    push(K_7FFD, 16'h7FFD, 8'h17);
    io_cycle(16'h7FFD, 8'h17, 1, 0, 0, 1);
    n_checks++;
    if (regs_now() !== 11'b000111_10001) begin
      n_fail++;
      $display("FAIL after_reset_out: got %b, required %b", regs_now(), 11'b000111_10001);
    end
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_strobes: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; za = 16'h0000; zd = 8'h00;
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; dos = 1'b0;
    #53 rst_n = 1'b1;
    test_reset();
    test_7ffd_basic();      drain("basic");
    test_lock_128k();       drain("lock");
    test_1m_mode();         drain("mode1m");
    test_f7_dos();          drain("f7");
    test_cycle_types();     drain("cycles");
    test_back_to_back();    drain("b2b");
    test_reset_mid_cycle(); drain("rstmid");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200us");
    $fatal(1, "timeout");
  end

endmodule
